tt_sweep_checker: RTL and testbench

//  Stimulus/compare stage that sits directly upstream of a combinational gold truth-table module and its

---
 rtl/dgd_sweep_pkg.sv | 22 ++
 rtl/tt_sweep_checker_if.sv | 41 ++++
 rtl/tt_sweep_settle_timer.sv | 35 +++
 rtl/tt_sweep_checker.sv | 148 ++++++++++++++
 tb/tb_tt_sweep_checker.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dgd_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dgd_sweep_pkg
// Description : Shared types and constants for the truth-table sweep checker.
// Revision    : 1.0 - initial release
// ============================================================================
package dgd_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sweep_state_e;

   localparam int SETTLE_W = 8;

   function automatic int tt_width(input int n_in);
      return 1 << n_in;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tt_sweep_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_checker_if
// Description : Control, circuit-drive and result bundle of the sweep checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface tt_sweep_checker_if
   import dgd_sweep_pkg::*;
#(
   parameter int N_IN = 4
) ();
   localparam int TT_W = tt_width(N_IN);

   logic            start;
   logic            abort;
   logic [N_IN-1:0] vec_o;
   logic            gold_i;
   logic            rev_i;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   mismatch_cnt;
   logic [N_IN-1:0] first_fail_vec;
   logic            first_fail_valid;
   logic [TT_W-1:0] tt_gold;
   logic [TT_W-1:0] tt_rev;

   // master: the checker itself; slave: controller plus the two circuits
   modport master (
      input  start, abort, gold_i, rev_i,
      output vec_o, busy, done, pass, mismatch_cnt,
             first_fail_vec, first_fail_valid, tt_gold, tt_rev
   );

   modport slave (
      output start, abort, gold_i, rev_i,
      input  vec_o, busy, done, pass, mismatch_cnt,
             first_fail_vec, first_fail_valid, tt_gold, tt_rev
   );
endinterface
`default_nettype wire

// File: rtl/tt_sweep_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_settle_timer
// Description : Down-counter that strobes once every SETTLE_CYCLES while running.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep_settle_timer
   import dgd_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic run,
   output logic sample
);
   localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   logic [SETTLE_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= RELOAD;
      end else if (run) begin
         count <= (count == '0) ? RELOAD : count - 1'b1;
      end
   end

   assign sample = run && (count == '0);

endmodule
`default_nettype wire

// File: rtl/tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_checker
// Description : Exhaustive gold-vs-revised truth-table sweep and compare stage.
//               Define TT_SWEEP_CAPTURE_EN to build the tt_gold/tt_rev capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep_checker
   import dgd_sweep_pkg::*;
#(
   parameter int N_IN          = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   tt_sweep_checker_if.master  bus
);
   localparam int              TT_W    = tt_width(N_IN);
   localparam logic [N_IN-1:0] VEC_ONE = 1;
   localparam logic [N_IN-1:0] VEC_PRE = N_IN'(TT_W - 2);
   localparam logic [N_IN:0]   CNT_ONE = 1;

   sweep_state_e    state;
   sweep_state_e    state_nxt;
   logic [N_IN-1:0] vec;
   logic            last_vec;
   logic [N_IN:0]   mismatch_cnt;
   logic [N_IN-1:0] ff_vec;
   logic            ff_valid;
   logic            sample;
   logic            busy;
   logic            done;
   logic            pass;

   logic accept;
   logic abort_run;
   logic take;
   logic miss;

   // start is only honoured outside RUN; abort only acts inside RUN
   assign accept    = bus.start && (state != ST_RUN);
   assign abort_run = bus.abort && (state == ST_RUN);
   assign take      = sample && !abort_run;
   assign miss      = bus.gold_i ^ bus.rev_i;

   tt_sweep_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .run    (state == ST_RUN),
      .sample (sample)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.start) state_nxt = ST_RUN;
         ST_RUN: begin
            if (abort_run)             state_nxt = ST_IDLE;
            else if (take && last_vec) state_nxt = ST_DONE;
         end
         ST_DONE: if (bus.start) state_nxt = ST_RUN;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_RUN);
      done = (state == ST_DONE);
      pass = (state == ST_DONE) && (mismatch_cnt == '0);
   end

   // last_vec is set as the counter steps onto all ones, so the counter never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec          <= '0;
         last_vec     <= 1'b0;
         mismatch_cnt <= '0;
         ff_vec       <= '0;
         ff_valid     <= 1'b0;
      end else if (accept) begin
         vec          <= '0;
         last_vec     <= 1'b0;
         mismatch_cnt <= '0;
         ff_vec       <= '0;
         ff_valid     <= 1'b0;
      end else if (abort_run) begin
         vec      <= '0;
         last_vec <= 1'b0;
      end else if (take) begin
         if (miss) begin
            mismatch_cnt <= mismatch_cnt + CNT_ONE;
            if (!ff_valid) begin
               ff_vec   <= vec;
               ff_valid <= 1'b1;
            end
         end
         if (!last_vec) begin
            vec      <= vec + VEC_ONE;
            last_vec <= (vec == VEC_PRE);
         end
      end
   end

`ifdef TT_SWEEP_CAPTURE_EN
   logic [TT_W-1:0] cap_gold;
   logic [TT_W-1:0] cap_rev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_gold <= '0;
         cap_rev  <= '0;
      end else if (accept) begin
         cap_gold <= '0;
         cap_rev  <= '0;
      end else if (take) begin
         cap_gold[vec] <= bus.gold_i;
         cap_rev[vec]  <= bus.rev_i;
      end
   end

   assign bus.tt_gold = cap_gold;
   assign bus.tt_rev  = cap_rev;
`else
   assign bus.tt_gold = '0;
   assign bus.tt_rev  = '0;
`endif

   assign bus.vec_o            = vec;
   assign bus.busy             = busy;
   assign bus.done             = done;
   assign bus.pass             = pass;
   assign bus.mismatch_cnt     = mismatch_cnt;
   assign bus.first_fail_vec   = ff_vec;
   assign bus.first_fail_valid = ff_valid;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_sweep_checker
// Description : Scoreboard bench for two checkers (settle 1 and settle 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_checker;

   typedef struct {
      int          cnt;
      int          ffv;
      int          ffvalid;
      int          pass;
      logic [15:0] tg;
      logic [15:0] tr;
      int          done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   logic [15:0] g_tt[2];
   logic [15:0] r_tt[2];
   logic        st[2];
   logic        ab[2];

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tt_sweep_checker_if #(.N_IN(4)) if1 ();
   tt_sweep_checker_if #(.N_IN(4)) if3 ();

   assign if1.start  = st[0];
   assign if1.abort  = ab[0];
   assign if1.gold_i = g_tt[0][if1.vec_o];
   assign if1.rev_i  = r_tt[0][if1.vec_o];
   assign if3.start  = st[1];
   assign if3.abort  = ab[1];
   assign if3.gold_i = g_tt[1][if3.vec_o];
   assign if3.rev_i  = r_tt[1][if3.vec_o];

   tt_sweep_checker #(.N_IN(4), .SETTLE_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
   tt_sweep_checker #(.N_IN(4), .SETTLE_CYCLES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.master));

   logic [3:0]  vec_s[2];
   logic        busy_s[2], done_s[2], pass_s[2], ffvalid_s[2];
   logic [4:0]  cnt_s[2];
   logic [3:0]  ffv_s[2];
   logic [15:0] tg_s[2], tr_s[2];

   assign vec_s[0] = if1.vec_o;          assign vec_s[1] = if3.vec_o;
   assign busy_s[0] = if1.busy;          assign busy_s[1] = if3.busy;
   assign done_s[0] = if1.done;          assign done_s[1] = if3.done;
   assign pass_s[0] = if1.pass;          assign pass_s[1] = if3.pass;
   assign cnt_s[0] = if1.mismatch_cnt;   assign cnt_s[1] = if3.mismatch_cnt;
   assign ffv_s[0] = if1.first_fail_vec; assign ffv_s[1] = if3.first_fail_vec;
   assign ffvalid_s[0] = if1.first_fail_valid;
   assign ffvalid_s[1] = if3.first_fail_valid;
   assign tg_s[0] = if1.tt_gold;         assign tg_s[1] = if3.tt_gold;
   assign tr_s[0] = if1.tt_rev;          assign tr_s[1] = if3.tt_rev;

   function automatic int settle_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: the sweep result is a pure function of the two truth tables
   function automatic exp_t model(input logic [15:0] g, input logic [15:0] r,
                                  input int start_cyc, input int s);
      exp_t        e;
      logic [15:0] diff;
      diff      = g ^ r;
      e.cnt     = $countones(diff);
      e.ffvalid = (diff != 16'h0) ? 1 : 0;
      e.ffv     = 0;
      for (int i = 15; i >= 0; i--) if (diff[i]) e.ffv = i;
      e.pass     = (diff == 16'h0) ? 1 : 0;
      e.tg       = g;
      e.tr       = r;
      e.done_cyc = start_cyc + 16 * s;
      return e;
   endfunction

   task automatic check_result(input int d, input exp_t e);
      logic [15:0] eg, er;
`ifdef TT_SWEEP_CAPTURE_EN
      eg = e.tg;
      er = e.tr;
`else
      eg = 16'h0;
      er = 16'h0;
`endif
      chk($sformatf("d%0d_latency", d), cyc, e.done_cyc);
      chk($sformatf("d%0d_cnt", d), {27'd0, cnt_s[d]}, e.cnt);
      chk($sformatf("d%0d_ffvalid", d), {31'd0, ffvalid_s[d]}, e.ffvalid);
      if (e.ffvalid != 0) chk($sformatf("d%0d_ffvec", d), {28'd0, ffv_s[d]}, e.ffv);
      chk($sformatf("d%0d_pass", d), {31'd0, pass_s[d]}, e.pass);
      chk($sformatf("d%0d_busy_at_done", d), {31'd0, busy_s[d]}, 0);
      chk($sformatf("d%0d_vec_hold", d), {28'd0, vec_s[d]}, 32'hF);
      chk($sformatf("d%0d_tt_gold", d), {16'd0, tg_s[d]}, {16'd0, eg});
      chk($sformatf("d%0d_tt_rev", d), {16'd0, tr_s[d]}, {16'd0, er});
   endtask

   task automatic check_zero(input int d, input string tag);
      chk($sformatf("%s_d%0d_vec", tag, d), {28'd0, vec_s[d]}, 0);
      chk($sformatf("%s_d%0d_busy", tag, d), {31'd0, busy_s[d]}, 0);
      chk($sformatf("%s_d%0d_done", tag, d), {31'd0, done_s[d]}, 0);
      chk($sformatf("%s_d%0d_pass", tag, d), {31'd0, pass_s[d]}, 0);
      chk($sformatf("%s_d%0d_cnt", tag, d), {27'd0, cnt_s[d]}, 0);
      chk($sformatf("%s_d%0d_ffvec", tag, d), {28'd0, ffv_s[d]}, 0);
      chk($sformatf("%s_d%0d_ffvalid", tag, d), {31'd0, ffvalid_s[d]}, 0);
      chk($sformatf("%s_d%0d_tt", tag, d), {tg_s[d], tr_s[d]}, 0);
   endtask

   // Monitor: pops an expectation on every rising done and checks vector pacing
   bit prev_done[2];
   bit prev_busy[2];
   int prev_vec[2];
   int run_len[2];

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst_n) begin
            if (done_s[d] && !prev_done[d]) begin
               if (d == 0 && q0.size() > 0)      check_result(0, q0.pop_front());
               else if (d == 1 && q1.size() > 0) check_result(1, q1.pop_front());
               else chk($sformatf("d%0d_unexpected_done_queue", d), 0, 1);
            end
            if (busy_s[d]) begin
               if (!prev_busy[d]) begin
                  chk($sformatf("d%0d_first_vec", d), {28'd0, vec_s[d]}, 0);
                  run_len[d] = 1;
               end else if (int'(vec_s[d]) == prev_vec[d]) begin
                  run_len[d]++;
               end else begin
                  chk($sformatf("d%0d_vec_step", d), {28'd0, vec_s[d]}, prev_vec[d] + 1);
                  chk($sformatf("d%0d_hold_len", d), run_len[d], settle_of(d));
                  run_len[d] = 1;
               end
            end
         end
         prev_done[d] = rst_n && done_s[d];
         prev_busy[d] = rst_n && busy_s[d];
         prev_vec[d]  = int'(vec_s[d]);
      end
   end

   task automatic run_sweep(input int d, input int ign_a, input int ign_b, input bit with_abort);
      int   t;
      int   rel;
      int   budget;
      exp_t e;
      @(negedge clk);
      t = cyc + 1;
      e = model(g_tt[d], r_tt[d], t, settle_of(d));
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      st[d] = 1'b1;
      ab[d] = with_abort;
      budget = 16 * settle_of(d) + 20;
      forever begin
         @(negedge clk);
         ab[d] = 1'b0;
         rel   = cyc - t;
         st[d] = (rel + 1 == ign_a) || (rel + 1 == ign_b);
         if (done_s[d] && !busy_s[d]) break;
         budget--;
         if (budget == 0) begin
            chk($sformatf("d%0d_sweep_timeout", d), 0, 1);
            break;
         end
      end
      st[d] = 1'b0;
      @(negedge clk);
   endtask

   task automatic abort_test(input int k);
      int t;
      @(negedge clk);
      t = cyc + 1;
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      while (cyc < t + k - 1) @(negedge clk);
      ab[0] = 1'b1;
      @(negedge clk);
      ab[0] = 1'b0;
      chk("abort_busy", {31'd0, busy_s[0]}, 0);
      chk("abort_done", {31'd0, done_s[0]}, 0);
      chk("abort_pass", {31'd0, pass_s[0]}, 0);
      chk("abort_vec", {28'd0, vec_s[0]}, 0);
      chk("abort_partial_cnt", {27'd0, cnt_s[0]},
          $countones((g_tt[0] ^ r_tt[0]) & ((16'h1 << (k - 1)) - 16'h1)));
      @(negedge clk);
      chk("abort_stays_idle", {31'd0, busy_s[0]}, 0);
   endtask

   initial begin
      logic [15:0] mask;
      for (int d = 0; d < 2; d++) begin
         st[d] = 1'b0; ab[d] = 1'b0;
         g_tt[d] = 16'hEF69; r_tt[d] = 16'hEF69;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero(0, "reset");
      check_zero(1, "reset");
      rst_n = 1'b1;

      run_sweep(0, 0, 0, 1'b0);
      r_tt[0] = 16'hEF69 ^ 16'h0020;
      run_sweep(0, 0, 0, 1'b0);
      r_tt[0] = 16'h0000;
      run_sweep(0, 0, 0, 1'b0);
      run_sweep(1, 5, 20, 1'b0);

      r_tt[0] = 16'hEF69 ^ 16'h0035;
      abort_test(7);
      run_sweep(0, 0, 0, 1'b0);
      r_tt[0] = 16'hEF69 ^ 16'h8001;
      run_sweep(0, 0, 0, 1'b1);

      for (int i = 0; i < 8; i++) begin
         int d;
         d    = i % 2;
         mask = 16'($urandom) & 16'($urandom);
         if ($urandom_range(0, 3) == 0) mask = 16'h0;
         g_tt[d] = 16'($urandom);
         r_tt[d] = g_tt[d] ^ mask;
         run_sweep(d, (d == 1) ? int'($urandom_range(1, 47)) : 0, 0, 1'b0);
      end

      g_tt[1] = 16'hEF69; r_tt[1] = 16'h1234;
      @(negedge clk);
      st[1] = 1'b1;
      @(negedge clk);
      st[1] = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_zero(0, "async_rst");
      check_zero(1, "async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      g_tt[0] = 16'hEF69; r_tt[0] = 16'hEF69;
      run_sweep(0, 0, 0, 1'b0);
      repeat (4) @(negedge clk);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
